// File: rtl/vga_rom_pixel_fetch_pkg.sv
// Shared constants and types for the VGA image-ROM pixel fetch path.
package vga_rom_pixel_fetch_pkg;

  localparam int unsigned CoordW    = 11;
  localparam logic        SyncIdle  = 1'b1;
  localparam int unsigned RomLatMin = 1;
  localparam int unsigned RomLatMax = 2;

  // RGB444 word layout: {r[11:8], g[7:4], b[3:0]}
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_rom_pixel_fetch_if.sv
// Bundle of scan-timing inputs, image ROM port and VGA pin outputs.
interface vga_rom_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 12
);
  import vga_rom_pixel_fetch_pkg::*;

  logic [CoordW-1:0] hcount;
  logic [CoordW-1:0] vcount;
  logic              video_on;
  logic              hsync_in;
  logic              vsync_in;
  logic [CoordW-1:0] pos_x;
  logic [CoordW-1:0] pos_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [3:0]        vga_r;
  logic [3:0]        vga_g;
  logic [3:0]        vga_b;
  logic              vga_hs;
  logic              vga_vs;

  // Pixel fetch block side
  modport master (
    input  hcount, vcount, video_on, hsync_in, vsync_in, pos_x, pos_y, rom_data,
    output rom_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

  // Timing generator / ROM / pins side
  modport slave (
    output hcount, vcount, video_on, hsync_in, vsync_in, pos_x, pos_y, rom_data,
    input  rom_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

endinterface

// File: rtl/vga_rom_pixel_fetch_delay_line.sv
// Resettable W-bit wide, N-stage shift register for latency matching.
module vga_rom_pixel_fetch_delay_line #(
  parameter int unsigned   W       = 1,
  parameter int unsigned   N       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [N-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_pipe[i] <= RST_VAL;
      end
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/vga_rom_pixel_fetch.sv
// Scan-coordinate to image-ROM address generator with magnified window, plus
// latency-matched RGB444 / sync output stage.
module vga_rom_pixel_fetch
  import vga_rom_pixel_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 17,
  parameter int unsigned        DATA_W    = 12,
  parameter int unsigned        IMG_W     = 320,
  parameter int unsigned        IMG_H     = 240,
  parameter int unsigned        SCALE     = 2,
  parameter int unsigned        H_ACTIVE  = 640,
  parameter int unsigned        V_ACTIVE  = 480,
  parameter int unsigned        ROM_LAT   = 1,
  parameter logic [DATA_W-1:0]  BG_COLOR  = 12'h000,
  parameter bit                 KEY_EN    = 1'b0,
  parameter logic [DATA_W-1:0]  KEY_COLOR = 12'hF0F
) (
  input logic                   clk,
  input logic                   rst,
  vga_rom_pixel_fetch_if.master bus
);

  localparam int unsigned LatEff = (ROM_LAT > RomLatMax) ? RomLatMax :
                                   (ROM_LAT < RomLatMin) ? RomLatMin : ROM_LAT;
  localparam int unsigned DlyN   = 1 + LatEff;
  localparam int unsigned RepW   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [CoordW:0]   WinW     = (CoordW+1)'(IMG_W * SCALE);
  localparam logic [CoordW:0]   WinH     = (CoordW+1)'(IMG_H * SCALE);
  localparam logic [CoordW-1:0] HActive  = CoordW'(H_ACTIVE);
  localparam logic [CoordW-1:0] VActive  = CoordW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(IMG_W);
  localparam logic [RepW-1:0]   RepLast  = RepW'(SCALE - 1);

  logic [CoordW-1:0] r_sx, r_sy;
  logic              r_armed;
  logic [ADDR_W-1:0] r_row_base, r_col, r_rom_addr;
  logic [RepW-1:0]   r_hrep, r_vrep;
  logic              r_in_win_prev;

  logic              w_frame_start, w_capture, w_armed_now, w_vis, w_in_win, w_win_ok;
  logic [CoordW:0]   w_h, w_v, w_sx, w_sy;
  logic [ADDR_W-1:0] w_row_base, w_row_base_d, w_col_d;
  logic [RepW-1:0]   w_vrep, w_vrep_d, w_hrep_d;

  assign w_frame_start = (bus.hcount == '0) && (bus.vcount == '0);
  assign w_capture     = (bus.hcount == '0) && (bus.vcount == VActive);
  assign w_armed_now   = r_armed | w_frame_start;

  assign w_h  = {1'b0, bus.hcount};
  assign w_v  = {1'b0, bus.vcount};
  assign w_sx = {1'b0, r_sx};
  assign w_sy = {1'b0, r_sy};

  assign w_vis    = bus.video_on && (bus.hcount < HActive) && (bus.vcount < VActive);
  assign w_in_win = w_vis && (w_h >= w_sx) && (w_h < w_sx + WinW) &&
                    (w_v >= w_sy) && (w_v < w_sy + WinH);
  assign w_win_ok = w_in_win & w_armed_now;

  // Frame start clears the row state in the same cycle so pixel (0,0) already sees base 0.
  always_comb begin
    w_row_base   = w_frame_start ? '0 : r_row_base;
    w_vrep       = w_frame_start ? '0 : r_vrep;
    w_row_base_d = w_row_base;
    w_vrep_d     = w_vrep;
    w_col_d      = '0;
    w_hrep_d     = '0;
    if (w_in_win) begin
      if (r_hrep == RepLast) begin
        w_col_d  = r_col + 1'b1;
        w_hrep_d = '0;
      end else begin
        w_col_d  = r_col;
        w_hrep_d = r_hrep + 1'b1;
      end
    end
    // Falling edge of in_win marks the end of a visible window line.
    if (r_in_win_prev && !w_in_win) begin
      if (w_vrep == RepLast) begin
        w_row_base_d = w_row_base + RowStep;
        w_vrep_d     = '0;
      end else begin
        w_vrep_d     = w_vrep + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_armed <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sx <= bus.pos_x;
        r_sy <= bus.pos_y;
      end
      r_armed <= w_armed_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_base    <= '0;
      r_vrep        <= '0;
      r_col         <= '0;
      r_hrep        <= '0;
      r_in_win_prev <= 1'b0;
      r_rom_addr    <= '0;
    end else begin
      r_row_base    <= w_row_base_d;
      r_vrep        <= w_vrep_d;
      r_col         <= w_col_d;
      r_hrep        <= w_hrep_d;
      r_in_win_prev <= w_in_win;
      if (w_in_win) begin
        r_rom_addr <= w_row_base + r_col;
      end
    end
  end

  assign bus.rom_addr = r_rom_addr;

  logic [3:0] w_dly;
  logic       w_vs_d, w_hs_d, w_video_on_d, w_win_ok_d;

  vga_rom_pixel_fetch_delay_line #(
    .W       (4),
    .N       (DlyN),
    .RST_VAL ({SyncIdle, SyncIdle, 1'b0, 1'b0})
  ) u_delay_line (
    .clk (clk),
    .rst (rst),
    .i_d ({bus.vsync_in, bus.hsync_in, bus.video_on, w_win_ok}),
    .o_q (w_dly)
  );

  assign {w_vs_d, w_hs_d, w_video_on_d, w_win_ok_d} = w_dly;

  logic [DATA_W-1:0] w_pix, r_pix;
  logic              r_hs, r_vs;
  rgb444_t           w_rgb;

  always_comb begin
    w_pix = bus.rom_data;
    if (!w_video_on_d) begin
      w_pix = '0;
    end else if (!w_win_ok_d) begin
      w_pix = BG_COLOR;
    end else if (KEY_EN && (bus.rom_data == KEY_COLOR)) begin
      w_pix = BG_COLOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
      r_hs  <= SyncIdle;
      r_vs  <= SyncIdle;
    end else begin
      r_pix <= w_pix;
      r_hs  <= w_hs_d;
      r_vs  <= w_vs_d;
    end
  end

  assign w_rgb      = rgb444_t'(r_pix);
  assign bus.vga_r  = w_rgb.r;
  assign bus.vga_g  = w_rgb.g;
  assign bus.vga_b  = w_rgb.b;
  assign bus.vga_hs = r_hs;
  assign bus.vga_vs = r_vs;

endmodule

// File: tb/tb_vga_rom_pixel_fetch.sv
// Scoreboard bench for vga_rom_pixel_fetch on a reduced screen geometry.
module tb_vga_rom_pixel_fetch;

  localparam int unsigned AddrW  = 17;
  localparam int unsigned DataW  = 12;
  localparam int          ImgW   = 8;
  localparam int          ImgH   = 6;
  localparam int          Scale  = 2;
  localparam int          HAct   = 20;
  localparam int          VAct   = 14;
  localparam int          HTot   = 24;
  localparam int          VTot   = 17;
  localparam int          RomLat = 1;
  localparam int          Lat    = 2 + RomLat;
  localparam logic [11:0] Bg     = 12'h123;
  localparam logic [11:0] Key    = 12'hF0F;

  typedef struct {
    int          h;
    int          v;
    logic [13:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   tests, fails;
  int   cur_h, cur_v, req_x, req_y, m_sx, m_sy;
  bit   m_armed;
  exp_t exp_q[$];

  vga_rom_pixel_fetch_if #(.ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  vga_rom_pixel_fetch #(
    .ADDR_W    (AddrW),
    .DATA_W    (DataW),
    .IMG_W     (ImgW),
    .IMG_H     (ImgH),
    .SCALE     (Scale),
    .H_ACTIVE  (HAct),
    .V_ACTIVE  (VAct),
    .ROM_LAT   (RomLat),
    .BG_COLOR  (Bg),
    .KEY_EN    (1'b1),
    .KEY_COLOR (Key)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [AddrW-1:0] a);
    logic [11:0] w;
    if (a == AddrW'(5)) return Key;
    w = 12'(a * 37 + 165);
    if (w == Key) w = 12'h0F0;
    return w;
  endfunction

  always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic prime_queue();
    exp_t e;
    exp_q.delete();
    e.h = -1;
    e.v = -1;
    e.val = {12'h000, 1'b1, 1'b1};
    for (int i = 0; i < Lat - 1; i++) exp_q.push_back(e);
    m_armed = 1'b0;
    m_sx = 0;
    m_sy = 0;
  endtask

  task automatic step();
    int          h, v, addr;
    bit          vis, win, hs, vs;
    logic [11:0] d, pix;
    exp_t        e;
    h = cur_h;
    v = cur_v;
    vis = (h < HAct) && (v < VAct);
    hs = !((h >= 21) && (h < 23));
    vs = (v != 15);
    bus.hcount   = 11'(h);
    bus.vcount   = 11'(v);
    bus.video_on = vis;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.pos_x    = 11'(req_x);
    bus.pos_y    = 11'(req_y);
    if (h == 0 && v == VAct) begin
      m_sx = req_x;
      m_sy = req_y;
    end
    if (h == 0 && v == 0) m_armed = 1'b1;
    win = vis && (h >= m_sx) && (h < m_sx + ImgW * Scale) &&
          (v >= m_sy) && (v < m_sy + ImgH * Scale);
    addr = win ? ((v - m_sy) / Scale) * ImgW + (h - m_sx) / Scale : 0;
    d = rom_f(AddrW'(addr));
    if (!vis) pix = 12'h000;
    else if (!m_armed || !win) pix = Bg;
    else if (d == Key) pix = Bg;
    else pix = d;
    e.h = h;
    e.v = v;
    e.val = {pix, hs, vs};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (win && m_armed)
      check($sformatf("addr(%0d,%0d)", h, v), 32'(bus.rom_addr), 32'(addr));
    if (exp_q.size() == Lat) begin
      e = exp_q.pop_front();
      check($sformatf("pins(%0d,%0d)", e.h, e.v),
            32'({bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs}), 32'(e.val));
    end
    cur_h++;
    if (cur_h == HTot) begin
      cur_h = 0;
      cur_v = (cur_v + 1) % VTot;
    end
  endtask

  task automatic run_to(input int th, input int tv);
    int n;
    n = 0;
    while (!(cur_h == th && cur_v == tv) && n < HTot * VTot) begin
      step();
      n++;
    end
    if (!(cur_h == th && cur_v == tv)) begin
      fails++;
      $error("FAIL run_to: stopped at (%0d,%0d) target (%0d,%0d)", cur_h, cur_v, th, tv);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(0));
    check({tag, "_hs"}, 32'(bus.vga_hs), 32'(1));
    check({tag, "_vs"}, 32'(bus.vga_vs), 32'(1));
    check({tag, "_addr"}, 32'(bus.rom_addr), 32'(0));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cur_h = 5;
    cur_v = 3;
    req_x = 0;
    req_y = 0;
    m_sx = 0;
    m_sy = 0;
    m_armed = 1'b0;

    // Power-on reset, released mid-frame: window shows BG until the next frame start.
    #1 rst = 1'b1;
    #1 check_reset_pins("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    prime_queue();
    run_to(0, 0);

    // Frame at (0,0); request a move on line 7 which must wait for blanking.
    run_to(0, 7);
    req_x = 4;
    req_y = 3;
    run_to(0, VAct);
    run_to(0, 0);

    // Frame at (4,3); change the request exactly on the capture cycle.
    run_to(0, VAct);
    req_x = 10;
    req_y = 5;
    run_to(0, 0);

    // Frame at (10,5), clipped right and bottom; async reset inside the window.
    run_to(14, 8);
    #2 rst = 1'b1;
    #1 check_reset_pins("mid");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    prime_queue();
    run_to(0, 0);
    run_to(0, VAct);
    run_to(0, 0);
    run_to(0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
